// File: rtl/serial_frame_checker_if.sv
// ---------------------------------------------------------------------------
// serial_frame_checker_if
// Purpose : groups the serial receive stream, the error-counter clear and the
//           per-frame result outputs of serial_frame_checker into one bundle.
// Signals :
//   rx_bit, rx_bit_valid, frame_start  serial input stream (master -> slave)
//   err_clr                            clear of the error counter (master -> slave)
//   data_out[7:0], syndrome[2:0]       result of the last completed frame
//   error_detected                     syndrome != 0 for the last completed frame
//   out_valid                          one-cycle pulse per completed frame
//   frame_abort                        one-cycle pulse per discarded partial frame
//   err_count[CNT_W-1:0]               saturating count of errored frames
// Modports: master = stream source / result consumer, slave = the checker.
// ---------------------------------------------------------------------------
interface serial_frame_checker_if #(
  parameter int CNT_W = 8
);
  logic             rx_bit;
  logic             rx_bit_valid;
  logic             frame_start;
  logic             err_clr;
  logic [7:0]       data_out;
  logic [2:0]       syndrome;
  logic             error_detected;
  logic             out_valid;
  logic             frame_abort;
  logic [CNT_W-1:0] err_count;

  modport master (
    output rx_bit, rx_bit_valid, frame_start, err_clr,
    input  data_out, syndrome, error_detected, out_valid, frame_abort, err_count
  );

  modport slave (
    input  rx_bit, rx_bit_valid, frame_start, err_clr,
    output data_out, syndrome, error_detected, out_valid, frame_abort, err_count
  );
endinterface

// File: rtl/serial_frame_checker.sv
// ---------------------------------------------------------------------------
// serial_frame_checker
// Purpose : receives 11-bit parity-protected byte frames (d0..d7, p1, p2, p3)
//           one bit per valid cycle, recomputes the three parity bits and
//           reports data, syndrome and an error flag per frame. Keeps a
//           saturating count of errored frames and discards frames that are
//           restarted (frame_start mid-frame) or stall longer than TIMEOUT.
//           Detection only: the syndrome aliases several bit positions, so no
//           correction is attempted.
// Ports   :
//   clk   clock
//   rst   synchronous active-high reset, highest priority
//   bus   serial_frame_checker_if.slave (stream in, results out)
// Parameters:
//   TIMEOUT  idle cycles tolerated mid-frame before abort (0 = never)
//   CNT_W    width of err_count
// ---------------------------------------------------------------------------
module serial_frame_checker #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_frame_checker_if.slave bus
);

  // Idle counter only ever needs to represent values below TIMEOUT.
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Data-bit coverage of p1, p2, p3 (index 0 = p1).
  localparam logic [2:0][7:0] PAR_MASK = {8'h8E, 8'h6D, 8'h5B};

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  // d0..d7, p1, p2; p3 is never stored because it arrives on the completing bit.
  logic [9:0]        bits_reg, bits_next;

  logic [7:0]        data_out_reg;
  logic [2:0]        syndrome_reg;
  logic              error_reg;
  logic              out_valid_reg;
  logic              frame_abort_reg;
  logic [CNT_W-1:0]  err_count_reg;

  logic              complete;
  logic              abort;
  logic              timeout_hit;
  logic [2:0]        recomputed;
  logic [2:0]        rx_par;
  logic [2:0]        syndrome_calc;

  // Parity is evaluated on the completing cycle: the data byte is fully stored
  // and p3 is the bit currently on the wire.
  assign rx_par = {bus.rx_bit, bits_reg[9], bits_reg[8]};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_parity
      assign recomputed[gi]    = ^(bits_reg[7:0] & PAR_MASK[gi]);
      assign syndrome_calc[gi] = recomputed[gi] ^ rx_par[gi];
    end
  endgenerate

  // The idle count is compared one step ahead so the abort is registered on
  // the cycle that makes the count reach TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) &&
                       (({1'b0, idle_cnt_reg} + 1'b1) == (IDLE_W + 1)'(TIMEOUT));

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    bits_next     = bits_reg;
    complete      = 1'b0;
    abort         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.rx_bit_valid && bus.frame_start) begin
          bits_next     = {9'd0, bus.rx_bit};
          bit_cnt_next  = 4'd1;
          idle_cnt_next = '0;
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.rx_bit_valid) begin
          idle_cnt_next = '0;
          if (bus.frame_start) begin
            // Restart wins even over what would have been the last bit.
            abort        = 1'b1;
            bits_next    = {9'd0, bus.rx_bit};
            bit_cnt_next = 4'd1;
          end else if (bit_cnt_reg == 4'd10) begin
            complete     = 1'b1;
            bit_cnt_next = 4'd0;
            state_next   = IDLE;
          end else begin
            bits_next[bit_cnt_reg] = bus.rx_bit;
            bit_cnt_next           = bit_cnt_reg + 4'd1;
          end
        end else if (timeout_hit) begin
          abort         = 1'b1;
          bit_cnt_next  = 4'd0;
          idle_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= 4'd0;
      idle_cnt_reg    <= '0;
      bits_reg        <= 10'd0;
      data_out_reg    <= 8'd0;
      syndrome_reg    <= 3'd0;
      error_reg       <= 1'b0;
      out_valid_reg   <= 1'b0;
      frame_abort_reg <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      bits_reg        <= bits_next;
      out_valid_reg   <= complete;
      frame_abort_reg <= abort;

      if (complete) begin
        data_out_reg <= bits_reg[7:0];
        syndrome_reg <= syndrome_calc;
        error_reg    <= |syndrome_calc;
      end

      // Clear wins over an increment landing in the same cycle.
      if (bus.err_clr) begin
        err_count_reg <= '0;
      end else if (complete && (|syndrome_calc) && (err_count_reg != {CNT_W{1'b1}})) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

  assign bus.data_out       = data_out_reg;
  assign bus.syndrome       = syndrome_reg;
  assign bus.error_detected = error_reg;
  assign bus.out_valid      = out_valid_reg;
  assign bus.frame_abort    = frame_abort_reg;
  assign bus.err_count      = err_count_reg;

endmodule
